// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: fetch/decode/execute/memory/writeback sequencing.
// Optional build macro MULTICYCLE_CTRL_ILLEGAL_TRAP_EN traps unrecognised opcodes in a sticky ILLEGAL state.
module multicycle_ctrl #(
   parameter int OP_WIDTH = 7,
   parameter int F3_WIDTH = 3
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [OP_WIDTH-1:0] op_i,
   input  logic [F3_WIDTH-1:0] funct3_i,
   input  logic                zero_i,
   input  logic                mem_ready_i,
   output logic                pc_write_o,
   output logic                adr_src_o,
   output logic                ir_write_o,
   output logic                mem_write_o,
   output logic                reg_write_o,
   output logic [1:0]          result_src_o,
   output logic [1:0]          alu_src_a_o,
   output logic [1:0]          alu_src_b_o,
   output logic [1:0]          alu_op_o,
   output logic [2:0]          imm_src_o,
   output logic                illegal_o
);

   localparam logic [OP_WIDTH-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OP_WIDTH-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OP_WIDTH-1:0] OP_RTYPE  = 7'b0110011;
   localparam logic [OP_WIDTH-1:0] OP_ITYPE  = 7'b0010011;
   localparam logic [OP_WIDTH-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OP_WIDTH-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OP_WIDTH-1:0] OP_LUI    = 7'b0110111;

   localparam logic [F3_WIDTH-1:0] F3_BEQ = 3'b000;
   localparam logic [F3_WIDTH-1:0] F3_BNE = 3'b001;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BRANCH,
      S_JAL,
      S_LUI,
      S_ILLEGAL
   } state_t;

   state_t state_reg, state_next;
   logic   taken;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= S_FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   // Only beq/bne are decoded; other funct3 values fall through as not taken.
   always_comb begin
      taken = 1'b0;
      if (funct3_i == F3_BEQ) begin
         taken = zero_i;
      end else if (funct3_i == F3_BNE) begin
         taken = !zero_i;
      end
   end

   always_comb begin
      state_next   = state_reg;
      pc_write_o   = 1'b0;
      adr_src_o    = 1'b0;
      ir_write_o   = 1'b0;
      mem_write_o  = 1'b0;
      reg_write_o  = 1'b0;
      result_src_o = 2'b00;
      alu_src_a_o  = 2'b00;
      alu_src_b_o  = 2'b00;
      alu_op_o     = 2'b00;
      imm_src_o    = 3'b000;
      illegal_o    = 1'b0;

      case (state_reg)
         S_FETCH: begin
            alu_src_b_o  = 2'b10;
            result_src_o = 2'b10;
            pc_write_o   = mem_ready_i;
            ir_write_o   = mem_ready_i;
            if (mem_ready_i) begin
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            // Old PC + immediate lands in ALUOut, ready for a taken branch.
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b01;
            imm_src_o   = (op_i == OP_JAL) ? 3'b100 : 3'b001;
            case (op_i)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_RTYPE:          state_next = S_EXECR;
               OP_ITYPE:          state_next = S_EXECI;
               OP_BRANCH:         state_next = S_BRANCH;
               OP_JAL:            state_next = S_JAL;
               OP_LUI:            state_next = S_LUI;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
               default:           state_next = S_ILLEGAL;
`else
               default:           state_next = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            alu_src_a_o = 2'b10;
            alu_src_b_o = 2'b01;
            if (op_i == OP_STORE) begin
               imm_src_o  = 3'b010;
               state_next = S_MEMWRITE;
            end else begin
               state_next = S_MEMREAD;
            end
         end
         S_MEMREAD: begin
            adr_src_o = 1'b1;
            if (mem_ready_i) begin
               state_next = S_MEMWB;
            end
         end
         S_MEMWB: begin
            result_src_o = 2'b01;
            reg_write_o  = 1'b1;
            state_next   = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src_o   = 1'b1;
            mem_write_o = 1'b1;
            if (mem_ready_i) begin
               state_next = S_FETCH;
            end
         end
         S_EXECR: begin
            alu_src_a_o = 2'b10;
            alu_op_o    = 2'b10;
            state_next  = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a_o = 2'b10;
            alu_src_b_o = 2'b01;
            alu_op_o    = 2'b10;
            state_next  = S_ALUWB;
         end
         S_LUI: begin
            alu_src_a_o = 2'b11;
            alu_src_b_o = 2'b01;
            imm_src_o   = 3'b011;
            state_next  = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_o = 1'b1;
            state_next  = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a_o = 2'b10;
            alu_op_o    = 2'b01;
            pc_write_o  = taken;
            state_next  = S_FETCH;
         end
         S_JAL: begin
            // PC takes the target from ALUOut while the ALU forms old PC + 4 for rd.
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b10;
            pc_write_o  = 1'b1;
            imm_src_o   = 3'b100;
            state_next  = S_ALUWB;
         end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
         S_ILLEGAL: begin
            illegal_o  = 1'b1;
            state_next = S_ILLEGAL;
         end
`endif
         default: begin
            state_next = S_FETCH;
         end
      endcase
   end

endmodule
